// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded operands and control from ID, inserts one bubble on a
// load-use dependency, freezes on data-cache stall, squashes on flush, and
// keeps a saturating count of inserted load-use bubbles.
module idex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] ifid_pc,
    input  logic [DATA_W-1:0] ifid_rdata1,
    input  logic [DATA_W-1:0] ifid_rdata2,
    input  logic [DATA_W-1:0] ifid_imm,
    input  logic [4:0]        ifid_rs1,
    input  logic [4:0]        ifid_rs2,
    input  logic [4:0]        ifid_rd,
    input  logic              ifid_uses_rs1,
    input  logic              ifid_uses_rs2,
    input  logic [7:0]        ifid_ctrl,
    input  logic              ifid_valid,
    input  logic              mem_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] idex_pc,
    output logic [DATA_W-1:0] idex_rdata1,
    output logic [DATA_W-1:0] idex_rdata2,
    output logic [DATA_W-1:0] idex_imm,
    output logic [4:0]        idex_rs1,
    output logic [4:0]        idex_rs2,
    output logic [4:0]        idex_rd,
    output logic              idex_regwrite,
    output logic              idex_memread,
    output logic              idex_memwrite,
    output logic              idex_memtoreg,
    output logic              idex_alusrc,
    output logic              idex_branch,
    output logic [1:0]        idex_aluop,
    output logic              idex_valid,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } action_t;

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [7:0]        r_ctrl;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_lu;
    logic              w_src_match;
    logic              w_front_en;
    logic              w_count_inc;
    action_t           w_action;

    // Load-use detection: EX holds a valid load whose rd feeds an ID source.
    always_comb begin
        w_src_match = (ifid_uses_rs1 && (r_rd == ifid_rs1)) ||
                      (ifid_uses_rs2 && (r_rd == ifid_rs2));
        w_lu        = r_valid && r_ctrl[6] && (r_rd != 5'd0) &&
                      ifid_valid && w_src_match;
    end

    // Per-cycle action select in priority order: stall, flush, load-use, load.
    always_comb begin
        w_action    = ACT_LOAD;
        w_front_en  = 1'b1;
        w_count_inc = 1'b0;
        if (mem_stall) begin
            w_action   = ACT_HOLD;
            w_front_en = 1'b0;
        end else if (flush) begin
            w_action   = ACT_BUBBLE;
        end else if (w_lu) begin
            w_action    = ACT_BUBBLE;
            w_front_en  = 1'b0;
            w_count_inc = 1'b1;
        end
    end

    // Pipeline register update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_ctrl   <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (w_action)
                ACT_LOAD: begin
                    r_pc     <= ifid_pc;
                    r_rdata1 <= ifid_rdata1;
                    r_rdata2 <= ifid_rdata2;
                    r_imm    <= ifid_imm;
                    r_rs1    <= ifid_rs1;
                    r_rs2    <= ifid_rs2;
                    r_rd     <= ifid_rd;
                    r_ctrl   <= ifid_ctrl;
                    r_valid  <= ifid_valid;
                end
                ACT_BUBBLE: begin
                    r_pc     <= '0;
                    r_rdata1 <= '0;
                    r_rdata2 <= '0;
                    r_imm    <= '0;
                    r_rs1    <= '0;
                    r_rs2    <= '0;
                    r_rd     <= '0;
                    r_ctrl   <= '0;
                    r_valid  <= 1'b0;
                end
                default: begin
                    r_pc     <= r_pc;
                    r_rdata1 <= r_rdata1;
                    r_rdata2 <= r_rdata2;
                    r_imm    <= r_imm;
                    r_rs1    <= r_rs1;
                    r_rs2    <= r_rs2;
                    r_rd     <= r_rd;
                    r_ctrl   <= r_ctrl;
                    r_valid  <= r_valid;
                end
            endcase
        end
    end

    // Saturating count of load-use bubbles only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bubble_count <= '0;
        end else if (w_count_inc && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + CNT_W'(1);
        end
    end

    assign pc_write      = w_front_en;
    assign ifid_write    = w_front_en;

    assign idex_pc       = r_pc;
    assign idex_rdata1   = r_rdata1;
    assign idex_rdata2   = r_rdata2;
    assign idex_imm      = r_imm;
    assign idex_rs1      = r_rs1;
    assign idex_rs2      = r_rs2;
    assign idex_rd       = r_rd;
    assign idex_regwrite = r_ctrl[7];
    assign idex_memread  = r_ctrl[6];
    assign idex_memwrite = r_ctrl[5];
    assign idex_memtoreg = r_ctrl[4];
    assign idex_alusrc   = r_ctrl[3];
    assign idex_branch   = r_ctrl[2];
    assign idex_aluop    = r_ctrl[1:0];
    assign idex_valid    = r_valid;
    assign bubble_count  = r_bubble_count;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed self-checking bench for idex_hazard_reg. A second instance with a
// 2-bit counter shares all inputs to exercise counter saturation.
module tb_idex_hazard_reg;

    localparam int DW = 32;

    localparam logic [7:0] CTRL_LW  = 8'hD8; // regwrite,memread,memtoreg,alusrc
    localparam logic [7:0] CTRL_ADD = 8'h82; // regwrite, aluop=10

    logic          clock;
    logic          reset;
    logic [DW-1:0] ifid_pc, ifid_rdata1, ifid_rdata2, ifid_imm;
    logic [4:0]    ifid_rs1, ifid_rs2, ifid_rd;
    logic          ifid_uses_rs1, ifid_uses_rs2;
    logic [7:0]    ifid_ctrl;
    logic          ifid_valid, mem_stall, flush;

    logic [DW-1:0] idex_pc, idex_rdata1, idex_rdata2, idex_imm;
    logic [4:0]    idex_rs1, idex_rs2, idex_rd;
    logic          idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg;
    logic          idex_alusrc, idex_branch, idex_valid;
    logic [1:0]    idex_aluop;
    logic          pc_write, ifid_write;
    logic [15:0]   bubble_count;

    logic [DW-1:0] s_pc, s_rdata1, s_rdata2, s_imm;
    logic [4:0]    s_rs1, s_rs2, s_rd;
    logic          s_regwrite, s_memread, s_memwrite, s_memtoreg;
    logic          s_alusrc, s_branch, s_valid;
    logic [1:0]    s_aluop;
    logic          s_pc_write, s_ifid_write;
    logic [1:0]    s_bubble_count;

    int checks = 0;
    int errors = 0;
    int exp_bc = 0;

    idex_hazard_reg #(.DATA_W(DW), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .ifid_pc(ifid_pc), .ifid_rdata1(ifid_rdata1), .ifid_rdata2(ifid_rdata2),
        .ifid_imm(ifid_imm), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rd(ifid_rd),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .ifid_ctrl(ifid_ctrl), .ifid_valid(ifid_valid),
        .mem_stall(mem_stall), .flush(flush),
        .idex_pc(idex_pc), .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2),
        .idex_imm(idex_imm), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg),
        .idex_alusrc(idex_alusrc), .idex_branch(idex_branch), .idex_aluop(idex_aluop),
        .idex_valid(idex_valid), .pc_write(pc_write), .ifid_write(ifid_write),
        .bubble_count(bubble_count)
    );

    idex_hazard_reg #(.DATA_W(DW), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .ifid_pc(ifid_pc), .ifid_rdata1(ifid_rdata1), .ifid_rdata2(ifid_rdata2),
        .ifid_imm(ifid_imm), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rd(ifid_rd),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .ifid_ctrl(ifid_ctrl), .ifid_valid(ifid_valid),
        .mem_stall(mem_stall), .flush(flush),
        .idex_pc(s_pc), .idex_rdata1(s_rdata1), .idex_rdata2(s_rdata2),
        .idex_imm(s_imm), .idex_rs1(s_rs1), .idex_rs2(s_rs2), .idex_rd(s_rd),
        .idex_regwrite(s_regwrite), .idex_memread(s_memread),
        .idex_memwrite(s_memwrite), .idex_memtoreg(s_memtoreg),
        .idex_alusrc(s_alusrc), .idex_branch(s_branch), .idex_aluop(s_aluop),
        .idex_valid(s_valid), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .bubble_count(s_bubble_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic [DW-1:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic [7:0] ctrl);
        ifid_pc       = pc;
        ifid_rdata1   = pc ^ 32'hA5A5_0000;
        ifid_rdata2   = pc ^ 32'h0000_5A5A;
        ifid_imm      = 32'h0000_0004;
        ifid_rs1      = rs1;
        ifid_rs2      = rs2;
        ifid_rd       = rd;
        ifid_uses_rs1 = u1;
        ifid_uses_rs2 = u2;
        ifid_ctrl     = ctrl;
        ifid_valid    = 1'b1;
    endtask

    task automatic clr_id;
        ifid_pc = '0; ifid_rdata1 = '0; ifid_rdata2 = '0; ifid_imm = '0;
        ifid_rs1 = '0; ifid_rs2 = '0; ifid_rd = '0;
        ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0;
        ifid_ctrl = '0; ifid_valid = 1'b0;
    endtask

    task automatic test_reset;
        // power-on state
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL por_valid got %0b exp 0", idex_valid); end
        checks++; if (bubble_count !== 16'd0) begin errors++; $display("FAIL por_count got %0d exp 0", bubble_count); end
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL por_write got %0b%0b exp 11", pc_write, ifid_write); end
        reset = 1'b0;
        set_id(32'h0000_0010, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, CTRL_ADD);
        tick;
        checks++; if (idex_pc !== 32'h10 || idex_valid !== 1'b1 || idex_regwrite !== 1'b1 || idex_aluop !== 2'b10) begin
            errors++; $display("FAIL load_basic got pc=%h v=%0b rw=%0b op=%b exp pc=10 v=1 rw=1 op=10", idex_pc, idex_valid, idex_regwrite, idex_aluop); end
        checks++; if (idex_rdata1 !== (32'h10 ^ 32'hA5A5_0000) || idex_imm !== 32'h4 || idex_rd !== 5'd3) begin
            errors++; $display("FAIL load_payload got r1=%h imm=%h rd=%0d", idex_rdata1, idex_imm, idex_rd); end
        // mid-cycle asynchronous reset
        #2 reset = 1'b1;
        #1;
        checks++; if (idex_valid !== 1'b0 || idex_pc !== '0 || idex_rd !== '0 || idex_regwrite !== 1'b0 || idex_rdata1 !== '0) begin
            errors++; $display("FAIL async_reset got v=%0b pc=%h rd=%0d rw=%0b exp all 0", idex_valid, idex_pc, idex_rd, idex_regwrite); end
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1 || bubble_count !== 16'd0) begin
            errors++; $display("FAIL async_reset_ctl got pw=%0b iw=%0b bc=%0d exp 1 1 0", pc_write, ifid_write, bubble_count); end
        reset = 1'b0;
        clr_id;
        tick;
        exp_bc = 0;
    endtask

    task automatic test_load_use;
        set_id(32'h100, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);   // lw x5
        tick;
        checks++; if (idex_memread !== 1'b1 || idex_rd !== 5'd5) begin errors++; $display("FAIL lu_load got mr=%0b rd=%0d exp 1 5", idex_memread, idex_rd); end
        set_id(32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ADD);  // add x6,x5,x7
        #1;
        checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin errors++; $display("FAIL lu_stall got %0b%0b exp 00", pc_write, ifid_write); end
        tick;
        exp_bc++;
        checks++; if (idex_valid !== 1'b0 || idex_regwrite !== 1'b0 || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL lu_bubble got v=%0b rw=%0b bc=%0d exp 0 0 %0d", idex_valid, idex_regwrite, bubble_count, exp_bc); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got %0b exp 1", pc_write); end
        tick;
        checks++; if (idex_rd !== 5'd6 || idex_rs1 !== 5'd5 || idex_valid !== 1'b1 || idex_pc !== 32'h104) begin
            errors++; $display("FAIL lu_consumer got rd=%0d rs1=%0d v=%0b pc=%h exp 6 5 1 104", idex_rd, idex_rs1, idex_valid, idex_pc); end
    endtask

    task automatic test_no_false_stall;
        set_id(32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_LW);   // lw x0
        tick;
        set_id(32'h204, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, CTRL_ADD);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL nostall_x0 got %0b exp 1", pc_write); end
        tick;
        checks++; if (idex_valid !== 1'b1 || idex_pc !== 32'h204 || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL nostall_x0_load got v=%0b pc=%h bc=%0d exp 1 204 %0d", idex_valid, idex_pc, bubble_count, exp_bc); end
        set_id(32'h208, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);   // lw x5
        tick;
        set_id(32'h20C, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, CTRL_ADD);  // rs2=5 unused
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL nostall_rs2 got %0b%0b exp 11", pc_write, ifid_write); end
        tick;
        checks++; if (idex_valid !== 1'b1 || idex_pc !== 32'h20C || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL nostall_rs2_load got v=%0b pc=%h bc=%0d exp 1 20c %0d", idex_valid, idex_pc, bubble_count, exp_bc); end
    endtask

    task automatic test_mem_stall;
        set_id(32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);
        tick;
        set_id(32'h304, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ADD);
        mem_stall = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin errors++; $display("FAIL stall_write got %0b%0b exp 00", pc_write, ifid_write); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (idex_pc !== 32'h300 || idex_rd !== 5'd5 || idex_memread !== 1'b1 || idex_valid !== 1'b1 ||
                          bubble_count !== 16'(exp_bc) || pc_write !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d] got pc=%h rd=%0d mr=%0b v=%0b bc=%0d pw=%0b exp 300 5 1 1 %0d 0",
                                   i, idex_pc, idex_rd, idex_memread, idex_valid, bubble_count, pc_write, exp_bc); end
        end
        mem_stall = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL stall_flush_write got %0b%0b exp 11", pc_write, ifid_write); end
        tick;
        checks++; if (idex_valid !== 1'b0 || idex_memread !== 1'b0 || idex_pc !== '0 || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL stall_flush_bubble got v=%0b mr=%0b pc=%h bc=%0d exp 0 0 0 %0d", idex_valid, idex_memread, idex_pc, bubble_count, exp_bc); end
        flush = 1'b0;
    endtask

    task automatic test_flush_over_lu;
        set_id(32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);
        tick;
        set_id(32'h404, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ADD);
        flush = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL flush_lu_write got %0b%0b exp 11", pc_write, ifid_write); end
        tick;
        checks++; if (idex_valid !== 1'b0 || idex_rd !== 5'd0 || idex_regwrite !== 1'b0 || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL flush_lu_bubble got v=%0b rd=%0d rw=%0b bc=%0d exp 0 0 0 %0d", idex_valid, idex_rd, idex_regwrite, bubble_count, exp_bc); end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back;
        set_id(32'h500, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);   // lw x5
        tick;
        set_id(32'h504, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, CTRL_LW);   // lw x8,4(x5)
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0b exp 0", pc_write); end
        tick;
        exp_bc++;
        checks++; if (idex_valid !== 1'b0 || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL b2b_bubble got v=%0b bc=%0d exp 0 %0d", idex_valid, bubble_count, exp_bc); end
        tick;
        checks++; if (idex_rd !== 5'd8 || idex_memread !== 1'b1 || idex_valid !== 1'b1 || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL b2b_second got rd=%0d mr=%0b v=%0b bc=%0d exp 8 1 1 %0d", idex_rd, idex_memread, idex_valid, bubble_count, exp_bc); end
        set_id(32'h508, 5'd3, 5'd8, 5'd9, 1'b0, 1'b1, CTRL_ADD);  // depends via rs2
        #1;
        checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin errors++; $display("FAIL b2b_rs2_stall got %0b%0b exp 00", pc_write, ifid_write); end
        tick;
        exp_bc++;
        checks++; if (idex_valid !== 1'b0 || bubble_count !== 16'(exp_bc)) begin
            errors++; $display("FAIL b2b_rs2_bubble got v=%0b bc=%0d exp 0 %0d", idex_valid, bubble_count, exp_bc); end
        clr_id;
        tick;
    endtask

    task automatic test_reset_mid_stall;
        set_id(32'h600, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);
        tick;
        mem_stall = 1'b1;
        tick;
        reset = 1'b1;
        #1;
        checks++; if (idex_valid !== 1'b0 || idex_rd !== 5'd0 || idex_memread !== 1'b0 || bubble_count !== 16'd0) begin
            errors++; $display("FAIL rst_stall got v=%0b rd=%0d mr=%0b bc=%0d exp 0 0 0 0", idex_valid, idex_rd, idex_memread, bubble_count); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_stall_pw got %0b exp 0", pc_write); end
        reset = 1'b0;
        mem_stall = 1'b0;
        exp_bc = 0;
        clr_id;
        tick;
    endtask

    task automatic test_saturation;
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            set_id(32'h700 + 32'(i * 8), 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);
            tick;
            set_id(32'h704 + 32'(i * 8), 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, CTRL_ADD);
            tick;
            exp_bc++;
            checks++; if (s_bubble_count !== 2'(sat_exp[i])) begin
                errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, s_bubble_count, sat_exp[i]); end
            checks++; if (bubble_count !== 16'(exp_bc)) begin
                errors++; $display("FAIL wide_count[%0d] got %0d exp %0d", i, bubble_count, exp_bc); end
        end
        checks++; if (s_valid !== 1'b0 || s_pc_write !== 1'b1 || s_ifid_write !== 1'b1) begin
            errors++; $display("FAIL sat_inst_state got v=%0b pw=%0b iw=%0b exp 0 1 1", s_valid, s_pc_write, s_ifid_write); end
        clr_id;
        tick;
    endtask

    initial begin
        reset = 1'b1;
        mem_stall = 1'b0;
        flush = 1'b0;
        clr_id;
        tick;
        test_reset;
        test_load_use;
        test_no_false_stall;
        test_mem_stall;
        test_flush_over_lu;
        test_back_to_back;
        test_reset_mid_stall;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
